// File: rtl/param_priority_arbiter.sv
// Registered N-way priority arbiter with grant lock (hold) and optional
// round-robin search start, enabled by defining the macro ROUND_ROBIN_EN.
module param_priority_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         hold,
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         valid
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t       state;
  logic [W-1:0] start;
  logic [W-1:0] win_idx;
  logic [W-1:0] pos_w;
  logic         win_found;
  logic         lock;
  int           pos;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  assign start = ptr;
`else
  assign start = W'(N - 1);
`endif

  // Descending search from start, wrapping from bit 0 back to bit N-1.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    pos       = 0;
    pos_w     = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) - k;
      if (pos < 0) pos = pos + N;
      pos_w = W'(pos);
      if (!win_found && req[pos_w]) begin
        win_found = 1'b1;
        win_idx   = pos_w;
      end
    end
  end

  assign lock = hold && (state != IDLE) && req[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      grant <= '0;
      valid <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr   <= W'(N - 1);
`endif
    end else if (en) begin
      if (lock) begin
        state <= LOCKED;
      end else if (win_found) begin
        state <= GRANT;
        idx   <= win_idx;
        grant <= {{(N-1){1'b0}}, 1'b1} << win_idx;
        valid <= 1'b1;
`ifdef ROUND_ROBIN_EN
        ptr   <= (win_idx == '0) ? W'(N - 1) : win_idx - W'(1);
`endif
      end else begin
        state <= IDLE;
        idx   <= '0;
        grant <= '0;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed plus randomized bench for param_priority_arbiter (N=8), checked
// against a rule-level reference model; follows ROUND_ROBIN_EN if defined.
module tb_param_priority_arbiter;

  localparam int N = 8;
  localparam int W = 3;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, hold;
  logic [N-1:0] req;
  logic [W-1:0] idx;
  logic [N-1:0] grant;
  logic         valid;

  int vectors = 0;
  int miscompares = 0;

  bit m_valid;
  int m_idx;
  int m_ptr;

  param_priority_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .req(req),
    .idx(idx), .grant(grant), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk priority positions start, start-1, ... with wrap.
  task automatic model_edge(input bit r, input bit e, input bit h, input logic [N-1:0] q);
    int start;
    int found;
    if (r) begin
      m_valid = 1'b0; m_idx = 0; m_ptr = N - 1;
    end else if (e) begin
      if (h && m_valid && q[m_idx]) begin
        // grant kept, pointer unchanged
      end else begin
        start = RR ? m_ptr : N - 1;
        found = -1;
        for (int k = 0; k < N; k++)
          if (found < 0 && q[(start - k + N) % N]) found = (start - k + N) % N;
        if (found >= 0) begin
          m_valid = 1'b1; m_idx = found; m_ptr = (found + N - 1) % N;
        end else begin
          m_valid = 1'b0; m_idx = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit h, input logic [N-1:0] q);
    logic [N-1:0] exp_grant;
    @(negedge clk);
    rst = r; en = e; hold = h; req = q;
    @(posedge clk);
    model_edge(r, e, h, q);
    #1;
    exp_grant = m_valid ? (N'(1) << m_idx) : '0;
    cmp("model_valid", 32'(valid), 32'(m_valid));
    cmp("model_idx", 32'(idx), 32'(m_idx));
    cmp("model_grant", 32'(grant), 32'(exp_grant));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; hold = 1'b0; req = '0;
    m_valid = 1'b0; m_idx = 0; m_ptr = N - 1;

    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'hFF);
    cmp("reset_valid", 32'(valid), 32'd0);
    cmp("reset_grant", 32'(grant), 32'd0);
    cmp("reset_idx", 32'(idx), 32'd0);

    step(0, 1, 0, 8'b0010_0110);
    cmp("first_idx", 32'(idx), 32'd5);
    cmp("first_grant", 32'(grant), 32'h20);
    cmp("first_valid", 32'(valid), 32'd1);

    step(0, 1, 0, 8'h00);
    cmp("idle_valid", 32'(valid), 32'd0);
    cmp("idle_grant", 32'(grant), 32'd0);

    step(0, 1, 0, 8'b0010_0110);
    step(0, 0, 0, 8'hFF);
    step(0, 0, 1, 8'h01);
    step(0, 0, 0, 8'h00);

    step(0, 1, 0, 8'b0000_0100);
    cmp("lock_setup_idx", 32'(idx), 32'd2);
    step(0, 1, 1, 8'b1000_0100);
    cmp("lock_hold_idx", 32'(idx), 32'd2);
    step(0, 1, 1, 8'b1000_0100);
    cmp("lock_hold2_grant", 32'(grant), 32'h04);
    step(0, 1, 1, 8'b1000_0000);
    cmp("lock_release_idx", 32'(idx), 32'd7);

    step(0, 1, 1, 8'b1000_0100);
    step(1, 1, 1, 8'hFF);
    cmp("rst_lock_valid", 32'(valid), 32'd0);
    cmp("rst_lock_idx", 32'(idx), 32'd0);
    step(0, 1, 0, 8'hFF);
    cmp("post_rst_idx", 32'(idx), 32'd7);

    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 8'hFF);
`ifdef ROUND_ROBIN_EN
      cmp("rr_sweep_idx", 32'(idx), 32'((6 - k + 8) % 8));
`else
      cmp("fixed_sweep_idx", 32'(idx), 32'd7);
`endif
    end

    step(0, 1, 0, 8'b0000_0001);
    cmp("wrap_setup_idx", 32'(idx), 32'd0);
    step(0, 1, 0, 8'b0000_0011);
    cmp("wrap_idx", 32'(idx), 32'd1);

    for (int n = 0; n < 500; n++) begin
      logic [N-1:0] q;
      q = N'($urandom) & N'($urandom | $urandom);
      step($urandom_range(0, 31) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 1) == 1, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_priority_arbiter.md
PARAM_PRIORITY_ARBITER -- requirements
Module: param_priority_arbiter

Interface
REQ-001 Parameter N, default 8, number of request inputs (legal 2..32).
REQ-002 Parameter W, default $clog2(N), width of the encoded index output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 en  input  1  arbitration enable; when low, registered outputs hold their values.
REQ-006 hold  input  1  grant-lock request; keeps the current grant while its requester stays active.
REQ-007 req  input  N  request vector; bit i high = requester i active.
REQ-008 idx  output  W  registered binary index of the granted requester.
REQ-009 grant  output  N  registered one-hot grant vector; bit idx set when valid.
REQ-010 valid  output  1  registered; high when a grant is present.

Function
REQ-011 The block shall sample req on each rising clk with en=1 and present the result on idx/grant/valid after exactly one cycle of latency.
REQ-012 With en=0 the block shall hold idx, grant, valid and internal state unchanged, whatever req and hold do.
REQ-013 Search order: fixed mode starts at bit N-1 and descends to bit 0; the first active bit wins.
REQ-014 With req all zero and en=1, the block shall drive valid=0, grant=0 and idx=0 on the next cycle.
REQ-015 grant shall equal (1 << idx) when valid=1, and shall be all zero when valid=0; it is never multi-hot.
REQ-016 Lock: if en=1, hold=1, valid=1 and req[idx]=1, the block shall keep idx/grant unchanged regardless of higher-priority requests.
REQ-017 Lock release: if hold=1 but req[idx]=0, the block shall perform normal arbitration that cycle.
REQ-018 States: IDLE (valid=0), GRANT (valid=1, unlocked), LOCKED (valid=1, lock applied last cycle).
REQ-019 Transitions: IDLE->GRANT on any req; GRANT->LOCKED per REQ-016; LOCKED->GRANT/IDLE on release per REQ-017; any state->IDLE on rst.
REQ-020 Lock applies only to an existing grant; from IDLE, hold=1 shall have no effect.
REQ-021 The index shall be computed as an unsigned W-bit value; for non-power-of-2 N, idx values >= N shall never appear.

Reset
REQ-022 On rst=1 at a rising clk edge: idx=0, grant=0, valid=0, state=IDLE, round-robin pointer=N-1.
REQ-023 rst shall take precedence over en, hold and req, including mid-lock.
REQ-024 On the first edge after rst deasserts, the block shall arbitrate normally (same rules as REQ-011).

Configuration
REQ-025 Macro ROUND_ROBIN_EN: when defined, the search shall start at pointer ptr, descend and wrap from bit 0 to bit N-1.
REQ-026 With ROUND_ROBIN_EN defined, after a new (non-locked) grant to i, ptr shall become (i-1) mod N; on an idle or locked cycle ptr shall not change.
REQ-027 Without ROUND_ROBIN_EN, no pointer register shall exist, and arbitration shall be fixed priority per REQ-013.
REQ-028 In both builds, the first arbitration after reset shall produce identical results (ptr=N-1).

Verification (N=8)
REQ-029 Bench shall cover a fixed build with en=1 and req=8'b0010_0110 -> next cycle idx=5, grant=8'b0010_0000, valid=1.
REQ-030 Bench shall cover req=0 after a grant -> next cycle valid=0, grant=0, idx=0; and en=0 with changing req -> outputs frozen.
REQ-031 Bench shall cover a lock: grant idx=2, then hold=1 with req=8'b1000_0100 -> idx stays 2; drop req[2] -> next cycle idx=7.
REQ-032 Bench shall cover an ROUND_ROBIN_EN build with req=8'hFF held for 9 cycles -> idx sequence 7,6,5,4,3,2,1,0,7.
REQ-033 Bench shall cover an ROUND_ROBIN_EN build: grant idx=0 (ptr->7), then req=8'b0000_0011 -> idx=1 (wrap path exercised).
REQ-034 Bench shall cover rst=1 asserted during LOCKED with req=8'hFF -> next edge valid=0, grant=0, idx=0; the first post-reset grant is idx=7.
